// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//   state_t / S_*   : sequencer state encoding
//   OE_*            : operand-select codes driven on oe1
//   ITER_*_DEF      : default Newton-Raphson iteration counts
//   is_slot()       : true for states that occupy a multiplier op slot
//   oe1_of()        : operand select presented while in a given state
package muldiv_pkg;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE  = 3'd0;
   localparam state_t S_MUL   = 3'd1;
   localparam state_t S_TABLE = 3'd2;
   localparam state_t S_IT_A  = 3'd3;
   localparam state_t S_IT_B  = 3'd4;
   localparam state_t S_QUOT  = 3'd5;
   localparam state_t S_REM   = 3'd6;
   localparam state_t S_DONE  = 3'd7;

   localparam logic [1:0] OE_FAFB  = 2'b11;
   localparam logic [1:0] OE_XFB   = 2'b01;
   localparam logic [1:0] OE_XCORR = 2'b10;
   localparam logic [1:0] OE_FAX   = 2'b00;

   localparam int ITER_DBL_DEF = 3;
   localparam int ITER_SGL_DEF = 2;

   function automatic logic is_slot(input state_t s);
      return (s == S_MUL) || (s == S_IT_A) || (s == S_IT_B) ||
             (s == S_QUOT) || (s == S_REM);
   endfunction

   function automatic logic [1:0] oe1_of(input state_t s);
      case (s)
         S_MUL:   return OE_FAFB;
         S_IT_A:  return OE_XFB;
         S_IT_B:  return OE_XCORR;
         S_QUOT:  return OE_FAX;
         S_REM:   return OE_XFB;
         default: return OE_FAX;
      endcase
   endfunction

endpackage

// File: rtl/muldiv_seq_lat_cnt.sv
// md_lat_cnt: multiplier latency down-counter that times one op slot.
//   clk, rst_n : clock, async active-low reset
//   load       : start a new slot (counter := MUL_LAT-1)
//   cnt_nxt    : value the counter takes at the next edge
//   last       : current cycle is the final cycle of the slot
module md_lat_cnt #(
   parameter int MUL_LAT = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   output logic [2:0] cnt_nxt,
   output logic       last
);

   localparam logic [2:0] LOAD_VAL = 3'(MUL_LAT - 1);

   logic [2:0] cnt;

   // Saturates at zero so an idle counter reads as "last" harmlessly.
   always_comb begin
      cnt_nxt = cnt;
      if (load)
         cnt_nxt = LOAD_VAL;
      else if (cnt != 3'd0)
         cnt_nxt = cnt - 3'd1;
   end

   assign last = (cnt == 3'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= 3'd0;
      else
         cnt <= cnt_nxt;
   end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: sequencer for the shared multiply/divide significand datapath.
// Multiply is one multiplier pass; divide runs a table seed, N Newton-Raphson
// iterations (two passes each), a quotient pass and a remainder-check pass.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : operation request handshake (fdiv, db sampled on accept)
//   flush               : abandon the current operation
//   mul_go, oe1, oe2    : multiplier issue, operand select, seed table enable
//   ld_x, ld_q          : capture strobes for approximation / quotient registers
//   iter                : current iteration index
//   busy                : operation in flight
//   out_valid/out_ready : result handshake
//
// state | meaning
// IDLE  | waiting for a request
// MUL   | single fa x fb multiplier pass
// TABLE | reciprocal seed lookup into x
// IT_A  | x_i x fb pass
// IT_B  | x_i x (2 - fb*x_i) pass, x updated at end of slot
// QUOT  | fa x x_final pass, quotient captured at end of slot
// REM   | remainder check pass
// DONE  | result presented until accepted
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int MUL_LAT  = 2,
   parameter int ITER_DBL = ITER_DBL_DEF,
   parameter int ITER_SGL = ITER_SGL_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       fdiv,
   input  logic       db,
   input  logic       flush,
   output logic       mul_go,
   output logic [1:0] oe1,
   output logic       oe2,
   output logic       ld_x,
   output logic       ld_q,
   output logic [1:0] iter,
   output logic       busy,
   output logic       out_valid,
   input  logic       out_ready
);

   state_t     state, state_nxt;
   logic       db_q;
   logic [1:0] iter_nxt;
   logic [1:0] iter_max;
   logic       slot_start;
   logic       last;
   logic [2:0] cnt_nxt;

   assign in_ready = (state == S_IDLE);
   assign iter_max = db_q ? 2'(ITER_DBL - 1) : 2'(ITER_SGL - 1);

   always_comb begin
      state_nxt = state;
      iter_nxt  = iter;
      case (state)
         S_IDLE:  if (in_valid) state_nxt = fdiv ? S_TABLE : S_MUL;
         S_MUL:   if (last) state_nxt = S_DONE;
         S_TABLE: begin
            state_nxt = S_IT_A;
            iter_nxt  = 2'd0;
         end
         S_IT_A:  if (last) state_nxt = S_IT_B;
         S_IT_B:  if (last) begin
            if (iter == iter_max) begin
               state_nxt = S_QUOT;
            end else begin
               state_nxt = S_IT_A;
               iter_nxt  = iter + 2'd1;
            end
         end
         S_QUOT:  if (last) state_nxt = S_REM;
         S_REM:   if (last) state_nxt = S_DONE;
         S_DONE:  if (out_ready) begin
            state_nxt = S_IDLE;
            iter_nxt  = 2'd0;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (flush) begin
         state_nxt = S_IDLE;
         iter_nxt  = 2'd0;
      end
   end

   // Every slot state exits to a different state, so a state change into a
   // slot state is exactly the issue cycle of a new op.
   assign slot_start = is_slot(state_nxt) && (state_nxt != state);

   md_lat_cnt #(.MUL_LAT(MUL_LAT)) u_lat_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (slot_start),
      .cnt_nxt (cnt_nxt),
      .last    (last)
   );

   // Outputs are registered from the next-state view so they line up with
   // the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         db_q      <= 1'b0;
         iter      <= 2'd0;
         mul_go    <= 1'b0;
         oe1       <= OE_FAX;
         oe2       <= 1'b0;
         ld_x      <= 1'b0;
         ld_q      <= 1'b0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         iter      <= iter_nxt;
         if (state == S_IDLE && in_valid && !flush)
            db_q <= db;
         mul_go    <= slot_start;
         oe1       <= oe1_of(state_nxt);
         oe2       <= (state_nxt == S_TABLE);
         ld_x      <= (state_nxt == S_TABLE) ||
                      ((state_nxt == S_IT_B) && (cnt_nxt == 3'd0));
         ld_q      <= (state_nxt == S_QUOT) && (cnt_nxt == 3'd0);
         busy      <= (state_nxt != S_IDLE);
         out_valid <= (state_nxt == S_DONE);
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;

   logic clk = 1'b0;
   logic rst_n, in_valid, in_valid1, fdiv, db, flush, out_ready;

   logic       in_ready, mul_go, oe2, ld_x, ld_q, busy, out_valid;
   logic [1:0] oe1, iter;
   logic       in_ready1, mul_go1, oe2_1, ld_x1, ld_q1, busy1, out_valid1;
   logic [1:0] oe1_1, iter1;

   int ncmp = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   muldiv_seq #(.MUL_LAT(2)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .fdiv(fdiv), .db(db), .flush(flush), .mul_go(mul_go), .oe1(oe1),
      .oe2(oe2), .ld_x(ld_x), .ld_q(ld_q), .iter(iter), .busy(busy),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   muldiv_seq #(.MUL_LAT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .fdiv(fdiv), .db(db), .flush(flush), .mul_go(mul_go1), .oe1(oe1_1),
      .oe2(oe2_1), .ld_x(ld_x1), .ld_q(ld_q1), .iter(iter1), .busy(busy1),
      .out_valid(out_valid1), .out_ready(out_ready)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // All registered outputs at reset values, in_ready high.
   task automatic chk_idle(input string tag);
      chk({tag, " mul_go"}, int'(mul_go), 0);
      chk({tag, " oe1"}, int'(oe1), 0);
      chk({tag, " oe2"}, int'(oe2), 0);
      chk({tag, " ld_x"}, int'(ld_x), 0);
      chk({tag, " ld_q"}, int'(ld_q), 0);
      chk({tag, " iter"}, int'(iter), 0);
      chk({tag, " busy"}, int'(busy), 0);
      chk({tag, " out_valid"}, int'(out_valid), 0);
      chk({tag, " in_ready"}, int'(in_ready), 1);
   endtask

   logic [1:0] exp_oe_dbl [8] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b01};
   logic [1:0] oe_seen [$];
   int first_ov, n_ldx, n_ldq, n_go, max_iter, n_ov;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_valid1 = 1'b0; fdiv = 1'b0; db = 1'b0;
      flush = 1'b0; out_ready = 1'b1;
      tick(); tick();
      chk_idle("reset");
      rst_n = 1'b1;
      tick();
      chk_idle("post_reset");

      // Multiply, double, out_ready high: issue t+1, result t+3, idle t+4.
      in_valid = 1'b1; fdiv = 1'b0; db = 1'b1;
      tick();                                   // t+1
      in_valid = 1'b0;
      chk("mul go t+1", int'(mul_go), 1);
      chk("mul oe1 t+1", int'(oe1), 3);
      chk("mul busy t+1", int'(busy), 1);
      chk("mul in_ready t+1", int'(in_ready), 0);
      tick();                                   // t+2
      chk("mul go t+2", int'(mul_go), 0);
      chk("mul oe1 held t+2", int'(oe1), 3);
      chk("mul ov t+2", int'(out_valid), 0);
      tick();                                   // t+3
      chk("mul ov t+3", int'(out_valid), 1);
      tick();                                   // t+4
      chk("mul ov t+4", int'(out_valid), 0);
      chk("mul in_ready t+4", int'(in_ready), 1);
      chk("mul busy t+4", int'(busy), 0);

      // Divide, double: oe2 at t+1, 8 ops, 4 ld_x, 1 ld_q, result t+18.
      in_valid = 1'b1; fdiv = 1'b1; db = 1'b1;
      oe_seen.delete(); first_ov = -1; n_ldx = 0; n_ldq = 0; n_go = 0; max_iter = 0;
      for (int c = 1; c <= 18; c++) begin
         tick();
         in_valid = 1'b0;
         if (c == 1) chk("div oe2 t+1", int'(oe2), 1);
         if (mul_go) begin oe_seen.push_back(oe1); n_go++; end
         if (ld_x) n_ldx++;
         if (ld_q) n_ldq++;
         if (int'(iter) > max_iter) max_iter = int'(iter);
         if (out_valid && first_ov < 0) first_ov = c;
      end
      chk("div dbl ov cycle", first_ov, 18);
      chk("div dbl mul_go count", n_go, 8);
      chk("div dbl ld_x count", n_ldx, 4);
      chk("div dbl ld_q count", n_ldq, 1);
      chk("div dbl max iter", max_iter, 2);
      for (int i = 0; i < 8; i++)
         if (i < oe_seen.size()) chk($sformatf("div dbl oe1[%0d]", i), int'(oe_seen[i]), int'(exp_oe_dbl[i]));
      tick();
      chk("div dbl in_ready after", int'(in_ready), 1);

      // Divide, single, MUL_LAT = 1: result t+8, iter peaks at 1.
      in_valid1 = 1'b1; fdiv = 1'b1; db = 1'b0;
      first_ov = -1; n_ldx = 0; n_ldq = 0; n_go = 0; max_iter = 0;
      for (int c = 1; c <= 8; c++) begin
         tick();
         in_valid1 = 1'b0;
         if (mul_go1) n_go++;
         if (ld_x1) n_ldx++;
         if (ld_q1) n_ldq++;
         if (int'(iter1) > max_iter) max_iter = int'(iter1);
         if (out_valid1 && first_ov < 0) first_ov = c;
      end
      chk("div sgl L1 ov cycle", first_ov, 8);
      chk("div sgl L1 max iter", max_iter, 1);
      chk("div sgl L1 mul_go count", n_go, 6);
      chk("div sgl L1 ld_x count", n_ldx, 3);
      chk("div sgl L1 ld_q count", n_ldq, 1);
      tick();
      chk("div sgl L1 in_ready after", int'(in_ready1), 1);

      // Divide, single, consumer stalls 5 cycles; new requests ignored.
      out_ready = 1'b0;
      in_valid = 1'b1; fdiv = 1'b1; db = 1'b0;
      first_ov = -1;
      for (int c = 1; c <= 14; c++) begin
         tick();
         in_valid = 1'b0;
         if (out_valid && first_ov < 0) first_ov = c;
      end
      chk("stall ov cycle", first_ov, 14);
      n_ov = 0;
      in_valid = 1'b1; fdiv = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (out_valid) n_ov++;
         chk($sformatf("stall in_ready %0d", c), int'(in_ready), 0);
         if (c < 4) tick();
      end
      chk("stall ov held cycles", n_ov, 5);
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      chk("stall ov released", int'(out_valid), 0);
      chk("stall in_ready released", int'(in_ready), 1);
      chk("stall busy released", int'(busy), 0);

      // Flush at t+7 of a double divide.
      in_valid = 1'b1; fdiv = 1'b1; db = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         tick();
         in_valid = 1'b0;
      end
      chk("flush pre busy", int'(busy), 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk_idle("flush t+8");
      in_valid = 1'b1; fdiv = 1'b0;
      tick(); in_valid = 1'b0;
      chk("post flush mul go", int'(mul_go), 1);
      tick(); tick();
      chk("post flush mul ov", int'(out_valid), 1);
      tick();

      // Flush coincident with an accept discards the request.
      in_valid = 1'b1; fdiv = 1'b1; flush = 1'b1;
      tick();
      in_valid = 1'b0; flush = 1'b0;
      chk("flush+accept busy", int'(busy), 0);
      chk("flush+accept oe2", int'(oe2), 0);

      // Async reset mid-IT_B, with in_valid held through reset.
      in_valid = 1'b1; fdiv = 1'b1; db = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         tick();
         in_valid = 1'b0;
      end
      chk("rst pre oe1 IT_B", int'(oe1), 2);
      #2;
      rst_n = 1'b0; in_valid = 1'b1; fdiv = 1'b0;
      #1;
      chk_idle("async rst");
      tick(); tick();
      chk("rst held busy", int'(busy), 0);
      chk("rst held mul_go", int'(mul_go), 0);
      rst_n = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("after rst accept busy", int'(busy), 1);
      chk("after rst accept mul_go", int'(mul_go), 1);
      tick(); tick();
      chk("after rst mul ov", int'(out_valid), 1);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
